// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and default constants for the multichannel serializer
// Contents: CHAN_W (channel index width), state_e (ST_IDLE/ST_SHIFT), DEF_* parameter defaults.
package ser_pkg;

    localparam int CHAN_W = 3;

    localparam int DEF_NUM_CHANNELS = 7;
    localparam int DEF_SAMPLE_BITS  = 8;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_CLKS_PER_BIT = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous per-channel sample FIFO with combinational head
// Ports: clk, reset (sync, active-high), push/din (write), pop (advance head),
//        dout (current head word), empty, full.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    // Full/empty are pre-edge values: a full FIFO refuses a push even when it
    // pops on the same edge, and an empty FIFO never pops the word being pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/multichannel_serializer.sv
// rtl/multichannel_serializer.sv - per-channel FIFOs shifted out in lockstep, MSB first
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_channel/in_data sample input;
//        underrun_clr pulse; ser_out (one line per channel), frame_sync, busy, underrun flags.
module multichannel_serializer
    import ser_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int SAMPLE_BITS  = DEF_SAMPLE_BITS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHAN_W-1:0]       in_channel,
    input  logic [SAMPLE_BITS-1:0]  in_data,
    input  logic                    underrun_clr,
    output logic [NUM_CHANNELS-1:0] ser_out,
    output logic                    frame_sync,
    output logic                    busy,
    output logic [NUM_CHANNELS-1:0] underrun
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(SAMPLE_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_BITS - 1);

    state_e                  state_q;
    logic [DIV_W-1:0]        div_cnt_q;
    logic [BIT_W-1:0]        bit_cnt_q;
    logic [SAMPLE_BITS-1:0]  shift_q [NUM_CHANNELS];
    logic                    frame_sync_q;
    logic                    busy_q;
    logic [NUM_CHANNELS-1:0] underrun_q;
    logic [NUM_CHANNELS-1:0] underrun_d;

    logic [NUM_CHANNELS-1:0] fifo_push;
    logic [NUM_CHANNELS-1:0] fifo_pop;
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [SAMPLE_BITS-1:0]  fifo_dout [NUM_CHANNELS];

    logic any_data;
    logic div_last;
    logic bit_last;
    logic load;

    // Out-of-range channels are always ready so the word is simply dropped.
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (in_channel == CHAN_W'(i)) begin
                in_ready = ~fifo_full[i];
            end
        end
    end

    always_comb begin
        fifo_push = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            fifo_push[i] = in_valid && in_ready && (in_channel == CHAN_W'(i));
        end
    end

    assign any_data = |(~fifo_empty);
    assign div_last = (div_cnt_q == DIV_LAST);
    assign bit_last = (bit_cnt_q == BIT_LAST);
    assign load     = any_data &&
                      ((state_q == ST_IDLE) || (div_last && bit_last));
    assign fifo_pop = {NUM_CHANNELS{load}} & ~fifo_empty;

    // A LOAD that marks a channel empty wins over a coincident clear.
    assign underrun_d = (underrun_q & ~{NUM_CHANNELS{underrun_clr}}) |
                        ({NUM_CHANNELS{load}} & fifo_empty);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_fifo
        sample_fifo #(
            .WIDTH (SAMPLE_BITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .din   (in_data),
            .dout  (fifo_dout[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            frame_sync_q <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shift_q[i] <= '0;
            end
        end else begin
            underrun_q <= underrun_d;
            if (load) begin
                state_q      <= ST_SHIFT;
                div_cnt_q    <= '0;
                bit_cnt_q    <= '0;
                frame_sync_q <= 1'b1;
                busy_q       <= 1'b1;
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    shift_q[i] <= fifo_empty[i] ? '0 : fifo_dout[i];
                end
            end else if (state_q == ST_SHIFT) begin
                if (!div_last) begin
                    div_cnt_q <= div_cnt_q + DIV_W'(1);
                end else if (!bit_last) begin
                    div_cnt_q    <= '0;
                    bit_cnt_q    <= bit_cnt_q + BIT_W'(1);
                    frame_sync_q <= 1'b0;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        shift_q[i] <= {shift_q[i][SAMPLE_BITS-2:0], 1'b0};
                    end
                end else begin
                    // Frame end with nothing queued: clear lines so IDLE drives zeros.
                    state_q      <= ST_IDLE;
                    div_cnt_q    <= '0;
                    bit_cnt_q    <= '0;
                    frame_sync_q <= 1'b0;
                    busy_q       <= 1'b0;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        shift_q[i] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        ser_out = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ser_out[i] = shift_q[i][SAMPLE_BITS-1];
        end
    end

    assign frame_sync = frame_sync_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_multichannel_serializer.sv
// tb/tb_multichannel_serializer.sv - directed self-checking bench for multichannel_serializer
module tb_multichannel_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_channel;
    logic [7:0] in_data;
    logic       underrun_clr;
    logic [6:0] ser_out;
    logic       frame_sync;
    logic       busy;
    logic [6:0] underrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    multichannel_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_channel   (in_channel),
        .in_data      (in_data),
        .underrun_clr (underrun_clr),
        .ser_out      (ser_out),
        .frame_sync   (frame_sync),
        .busy         (busy),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_channel   = 3'd0;
        in_data      = 8'h00;
        underrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    // Offers one word; accepted on the next rising edge (caller ensures ready).
    task automatic push(input logic [2:0] ch, input logic [7:0] d);
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ser_out !== 7'h00) begin n_err++; $display("FAIL reset_ser_out got %h exp 00", ser_out); end
        n_cmp++; if (frame_sync !== 1'b0) begin n_err++; $display("FAIL reset_frame_sync got %b exp 0", frame_sync); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (underrun !== 7'h00) begin n_err++; $display("FAIL reset_underrun got %h exp 00", underrun); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        logic [6:0] exp_vec;
        w = 8'hA5;
        do_reset();
        push(3'd0, w);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_before_load got %b exp 0", busy); end
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            exp_vec = '0;
            exp_vec[0] = w[7 - j / 4];
            n_cmp++; if (ser_out !== exp_vec) begin n_err++; $display("FAIL single_ser_out cyc %0d got %h exp %h", j, ser_out, exp_vec); end
            n_cmp++; if (frame_sync !== (j < 4)) begin n_err++; $display("FAIL single_frame_sync cyc %0d got %b exp %b", j, frame_sync, (j < 4)); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy cyc %0d got %b exp 1", j, busy); end
        end
        n_cmp++; if (underrun !== 7'b1111110) begin n_err++; $display("FAIL single_underrun got %b exp 1111110", underrun); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got %b exp 0", busy); end
        n_cmp++; if (ser_out !== 7'h00) begin n_err++; $display("FAIL single_ser_out_end got %h exp 00", ser_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        logic [6:0] exp_vec;
        do_reset();
        push(3'd2, 8'h01);
        push(3'd2, 8'h80);
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            w = (j < 32) ? 8'h01 : 8'h80;
            exp_vec = '0;
            exp_vec[2] = w[7 - (j % 32) / 4];
            n_cmp++; if (ser_out !== exp_vec) begin n_err++; $display("FAIL b2b_ser_out cyc %0d got %h exp %h", j, ser_out, exp_vec); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy cyc %0d got %b exp 1", j, busy); end
            n_cmp++; if (frame_sync !== ((j % 32) < 4)) begin n_err++; $display("FAIL b2b_frame_sync cyc %0d got %b exp %b", j, frame_sync, ((j % 32) < 4)); end
        end
        n_cmp++; if (underrun !== 7'b1111011) begin n_err++; $display("FAIL b2b_underrun got %b exp 1111011", underrun); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_fifo_full();
        int   t0;
        int   acc;
        logic ready_seen;
        do_reset();
        push(3'd0, 8'hFF);
        t0 = cyc;
        push(3'd3, 8'h80);
        push(3'd3, 8'h11);
        push(3'd3, 8'h22);
        push(3'd3, 8'h33);
        in_channel = 3'd3;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_ch3 got %b exp 0", in_ready); end
        in_channel = 3'd4;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_ch4 got %b exp 1", in_ready); end
        in_channel = 3'd3;
        in_data    = 8'h5C;
        in_valid   = 1'b1;
        acc = -1;
        for (int k = 0; k < 100 && acc < 0; k++) begin
            @(negedge clk);
            ready_seen = in_ready;
            @(posedge clk);
            #1;
            if (ready_seen) acc = cyc;
        end
        in_valid = 1'b0;
        n_cmp++; if (acc !== t0 + 34) begin n_err++; $display("FAIL full_fifth_accept got edge %0d exp %0d", acc, t0 + 34); end
        @(negedge clk);
        n_cmp++; if (ser_out[3] !== 1'b1) begin n_err++; $display("FAIL full_ch3_first_bit got %b exp 1", ser_out[3]); end
        n_cmp++; if (frame_sync !== 1'b1) begin n_err++; $display("FAIL full_frame2_sync got %b exp 1", frame_sync); end
    endtask

    task automatic test_invalid_channel();
        do_reset();
        in_channel = 3'd7;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL invalid_ready got %b exp 1", in_ready); end
        push(3'd7, 8'h3C);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL invalid_busy cyc %0d got %b exp 0", j, busy); end
            n_cmp++; if (underrun !== 7'h00) begin n_err++; $display("FAIL invalid_underrun cyc %0d got %h exp 00", j, underrun); end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        push(3'd1, 8'hFF);
        push(3'd1, 8'h0F);
        repeat (13) @(negedge clk);
        n_cmp++; if (ser_out !== 7'b0000010) begin n_err++; $display("FAIL midrst_pre_ser_out got %b exp 0000010", ser_out); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (ser_out !== 7'h00) begin n_err++; $display("FAIL midrst_ser_out got %h exp 00", ser_out); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
        n_cmp++; if (underrun !== 7'h00) begin n_err++; $display("FAIL midrst_underrun got %h exp 00", underrun); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_fifo_empty busy got %b exp 0", busy); end
    endtask

    task automatic test_underrun_clr();
        int waited;
        do_reset();
        push(3'd0, 8'h11);
        @(posedge clk);
        #1;
        n_cmp++; if (underrun !== 7'b1111110) begin n_err++; $display("FAIL uclr_set got %b exp 1111110", underrun); end
        underrun_clr = 1'b1;
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        n_cmp++; if (underrun !== 7'h00) begin n_err++; $display("FAIL uclr_clear got %h exp 00", underrun); end
        waited = 0;
        while (busy === 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL uclr_idle_timeout busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (underrun !== 7'h00) begin n_err++; $display("FAIL uclr_idle_no_set got %h exp 00", underrun); end
        push(3'd0, 8'h22);
        underrun_clr = 1'b1;
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        n_cmp++; if (underrun !== 7'b1111110) begin n_err++; $display("FAIL uclr_set_wins got %b exp 1111110", underrun); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL uclr_load_busy got %b exp 1", busy); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fifo_full();
        test_invalid_channel();
        test_reset_mid_frame();
        test_underrun_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
